// File: rtl/dct2d_engine.sv
// dct2d_engine: streaming 8x8 inverse/forward DCT.
// Row-column decomposition on one time-shared multiply-accumulate unit, with
// 64-entry input, transpose and output buffers and valid/ready handshakes.
module dct2d_engine #(
    parameter int DW = 10,
    parameter int OW = 10,
    parameter int MW = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mode,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic signed [OW-1:0] out_data,
    output logic [5:0]           out_addr,
    input  logic                 out_ready,
    output logic                 busy
);

    localparam int KW   = 13;
    localparam int AW   = (DW > MW) ? DW : MW;
    localparam int PW   = AW + KW;
    localparam int ACCW = PW + 3;

    localparam logic signed [ACCW-1:0] T_MAX = ACCW'(2 ** (MW - 1) - 1);
    localparam logic signed [ACCW-1:0] T_MIN = ACCW'(-(2 ** (MW - 1)));
    localparam logic signed [ACCW-1:0] O_MAX = ACCW'(2 ** (OW - 1) - 1);
    localparam logic signed [ACCW-1:0] O_MIN = ACCW'(-(2 ** (OW - 1)));

    typedef enum logic [1:0] {LOAD, PASS1, PASS2, OUT} state_t;

    state_t state, next_state;

    logic [5:0] load_cnt;
    logic [9:0] mac_cnt;
    logic [5:0] out_cnt;
    logic       blk_mode;

    logic signed [DW-1:0] ibuf [64];
    logic signed [MW-1:0] tbuf [64];
    logic signed [OW-1:0] obuf [64];

    logic in_fire, out_fire;

    // Issue-stage signals
    logic [5:0]           res_idx;
    logic [2:0]           term, row, col;
    logic                 issue;
    logic signed [AW-1:0] opnd;
    logic signed [KW-1:0] kc;

    // Pipeline registers: operand fetch, then product
    logic                 va, first_a, last_a, pass2_a;
    logic [5:0]           addr_a;
    logic signed [AW-1:0] a_q;
    logic signed [KW-1:0] k_q;
    logic                 vb, first_b, last_b, pass2_b;
    logic [5:0]           addr_b;
    logic signed [PW-1:0] p_q;

    // Accumulate and writeback
    logic signed [ACCW-1:0] acc, acc_sum, rnd;
    logic signed [MW-1:0]   t_val;
    logic signed [OW-1:0]   o_val;
    logic                   t_we, o_we;

    // K[u][x] = round(2048*c(u)*cos((2x+1)u*pi/16)), folded onto one quadrant
    function automatic logic signed [KW-1:0] coef(input logic [2:0] u, input logic [2:0] x);
        int  m;
        int  mag;
        logic neg;
        m = ((2 * int'(x) + 1) * int'(u)) % 32;
        if (m > 16) m = 32 - m;
        neg = (m > 8);
        if (neg) m = 16 - m;
        case (m)
            0:       mag = 2048;
            1:       mag = 2009;
            2:       mag = 1892;
            3:       mag = 1703;
            4:       mag = 1448;
            5:       mag = 1138;
            6:       mag = 784;
            7:       mag = 400;
            default: mag = 0;
        endcase
        if (u == 3'd0) begin
            mag = 1448;
            neg = 1'b0;
        end
        return neg ? KW'(-mag) : KW'(mag);
    endfunction

    assign in_fire  = in_valid && (state == LOAD);
    assign out_fire = out_ready && (state == OUT);

    assign res_idx = mac_cnt[8:3];
    assign term    = mac_cnt[2:0];
    assign row     = res_idx[5:3];
    assign col     = res_idx[2:0];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= LOAD;
        else       state <= next_state;
    end

    // Next-state decode and handshake outputs
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        out_data   = '0;
        out_addr   = '0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_fire && load_cnt == 6'd63) next_state = PASS1;
            end
            PASS1: begin
                if (mac_cnt == 10'd511) next_state = PASS2;
            end
            PASS2: begin
                // two extra cycles let the last result drain through the pipeline
                if (mac_cnt == 10'd513) next_state = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                out_data  = obuf[out_cnt];
                out_addr  = out_cnt;
                if (out_fire && out_cnt == 6'd63) next_state = LOAD;
            end
            default: next_state = LOAD;
        endcase
    end

    // Block counters and the per-block mode latch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_cnt <= '0;
            mac_cnt  <= '0;
            out_cnt  <= '0;
            blk_mode <= 1'b0;
        end else begin
            if (in_fire) begin
                load_cnt <= load_cnt + 6'd1;
                if (load_cnt == 6'd0) blk_mode <= mode;
            end
            if (state != next_state)
                mac_cnt <= '0;
            else if (state == PASS1 || state == PASS2)
                mac_cnt <= mac_cnt + 10'd1;
            if (out_fire) out_cnt <= out_cnt + 6'd1;
        end
    end

    // Operand and coefficient selection for the current MAC term
    always_comb begin
        issue = 1'b0;
        opnd  = '0;
        kc    = '0;
        case (state)
            PASS1: begin
                issue = 1'b1;
                opnd  = AW'(ibuf[{row, term}]);
                kc    = blk_mode ? coef(col, term) : coef(term, col);
            end
            PASS2: begin
                issue = !mac_cnt[9];
                opnd  = AW'(tbuf[{term, col}]);
                kc    = blk_mode ? coef(row, term) : coef(term, row);
            end
            default: ;
        endcase
    end

    // Fetch and multiply pipeline stages plus the running accumulator
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            va      <= 1'b0;
            first_a <= 1'b0;
            last_a  <= 1'b0;
            pass2_a <= 1'b0;
            addr_a  <= '0;
            a_q     <= '0;
            k_q     <= '0;
            vb      <= 1'b0;
            first_b <= 1'b0;
            last_b  <= 1'b0;
            pass2_b <= 1'b0;
            addr_b  <= '0;
            p_q     <= '0;
            acc     <= '0;
        end else begin
            va      <= issue;
            first_a <= (term == 3'd0);
            last_a  <= (term == 3'd7);
            pass2_a <= (state == PASS2);
            addr_a  <= res_idx;
            a_q     <= opnd;
            k_q     <= kc;
            vb      <= va;
            first_b <= first_a;
            last_b  <= last_a;
            pass2_b <= pass2_a;
            addr_b  <= addr_a;
            p_q     <= PW'(a_q) * PW'(k_q);
            if (vb) acc <= acc_sum;
        end
    end

    // Round the finished 8-term sum and saturate it for its destination
    always_comb begin
        acc_sum = (first_b ? ACCW'(0) : acc) + ACCW'(p_q);
        rnd     = (acc_sum + ACCW'(2048)) >>> 12;
        if (rnd > T_MAX)      t_val = T_MAX[MW-1:0];
        else if (rnd < T_MIN) t_val = T_MIN[MW-1:0];
        else                  t_val = rnd[MW-1:0];
        if (rnd > O_MAX)      o_val = O_MAX[OW-1:0];
        else if (rnd < O_MIN) o_val = O_MIN[OW-1:0];
        else                  o_val = rnd[OW-1:0];
        t_we = vb && last_b && !pass2_b;
        o_we = vb && last_b && pass2_b;
    end

    // Input sample buffer
    always_ff @(posedge clk) begin
        if (in_fire) ibuf[load_cnt] <= in_data;
    end

    // Transpose buffer written at the end of each first-pass sum
    always_ff @(posedge clk) begin
        if (t_we) tbuf[addr_b] <= t_val;
    end

    // Output buffer written at the end of each second-pass sum
    always_ff @(posedge clk) begin
        if (o_we) obuf[addr_b] <= o_val;
    end

endmodule

// File: tb/tb_dct2d_engine.sv
// tb_dct2d_engine: directed checks of dct2d_engine against hand-computed blocks.
module tb_dct2d_engine;

    localparam int DW = 10;
    localparam int OW = 10;
    localparam int MW = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 mode;
    logic                 in_valid;
    logic signed [DW-1:0] in_data;
    logic                 in_ready;
    logic                 out_valid;
    logic signed [OW-1:0] out_data;
    logic [5:0]           out_addr;
    logic                 out_ready;
    logic                 busy;

    int tests_run    = 0;
    int tests_failed = 0;
    int in_mem  [64];
    int exp_mem [64];
    int got_mem [64];
    int orig_mem[64];
    int tol;

    dct2d_engine #(.DW(DW), .OW(OW), .MW(MW)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_ready (out_ready),
        .busy      (busy)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic expectEqual(input string tag, input logic signed [31:0] observed, input int expected);
        tests_run++;
        assert (observed === 32'(expected)) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic expectNear(input string tag, input logic signed [31:0] observed, input int expected, input int margin);
        tests_run++;
        assert ((observed >= 32'(expected - margin)) && (observed <= 32'(expected + margin))) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0d expected=%0d+/-%0d", tag, observed, expected, margin);
        end
    endtask

    // Stream in_mem as one block; optionally flip mode on odd beats
    task automatic applyStimulus(input logic m, input bit toggle_mode);
        for (int i = 0; i < 64; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(in_mem[i]);
            mode     = (toggle_mode && (i % 2 == 1)) ? ~m : m;
            if (i == 0) expectEqual("in_ready_at_load", in_ready, 1);
            @(posedge clk);
            #1;
        end
        in_data = DW'(341);
        mode    = ~m;
        expectEqual("in_ready_after_load", in_ready, 0);
        expectEqual("busy_after_load", busy, 1);
    endtask

    // Wait for the result with junk held on the input port
    task automatic waitForOutput();
        int n;
        n = 0;
        while (!out_valid && n < 1100) begin
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        expectEqual("latency", n, 1026);
    endtask

    // Drain one output block, comparing to exp_mem within tol
    task automatic checkOutput(input bit stall);
        int beat;
        int cyc;
        bit stalled;
        logic [5:0] prev_addr;
        logic signed [OW-1:0] prev_data;
        beat = 0;
        cyc = 0;
        stalled = 1'b0;
        prev_addr = '0;
        prev_data = '0;
        while (beat < 64 && cyc < 3000) begin
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            expectEqual("in_ready_during_out", in_ready, 0);
            if (stalled) begin
                expectEqual("addr_stable", out_addr, prev_addr);
                expectEqual("data_stable", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                expectEqual("out_addr_seq", out_addr, beat);
                expectNear("out_data", out_data, exp_mem[beat], tol);
                got_mem[beat] = int'(out_data);
                beat++;
                stalled = 1'b0;
            end else begin
                stalled = out_valid;
            end
            prev_addr = out_addr;
            prev_data = out_data;
            @(posedge clk);
            #1;
            cyc++;
        end
        out_ready = 1'b0;
        expectEqual("out_beats", beat, 64);
        if (!stall) expectEqual("out_cycles", cyc, 64);
        expectEqual("in_ready_after_out", in_ready, 1);
        expectEqual("out_valid_after_out", out_valid, 0);
    endtask

    // Directed test sequence
    initial begin
        reset     = 1'b1;
        mode      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tol       = 0;
        repeat (2) @(posedge clk);
        #1;
        expectEqual("rst_in_ready", in_ready, 1);
        expectEqual("rst_out_valid", out_valid, 0);
        expectEqual("rst_busy", busy, 0);
        expectEqual("rst_out_data", out_data, 0);
        expectEqual("rst_out_addr", out_addr, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        expectEqual("idle_in_ready", in_ready, 1);
        expectEqual("idle_busy", busy, 0);

        $display("[TB] IDCT DC block");
        for (int i = 0; i < 64; i++) begin
            in_mem[i]  = (i == 0) ? 64 : 0;
            exp_mem[i] = 8;
        end
        applyStimulus(1'b0, 1'b0);
        waitForOutput();
        checkOutput(1'b0);

        $display("[TB] IDCT rounding block");
        for (int i = 0; i < 64; i++) begin
            in_mem[i]  = (i == 0) ? 511 : 0;
            exp_mem[i] = 64;
        end
        applyStimulus(1'b0, 1'b0);
        waitForOutput();
        checkOutput(1'b0);

        $display("[TB] DCT saturation block");
        for (int i = 0; i < 64; i++) begin
            in_mem[i]  = 511;
            exp_mem[i] = (i == 0) ? 511 : 0;
        end
        applyStimulus(1'b1, 1'b0);
        waitForOutput();
        checkOutput(1'b0);

        $display("[TB] DCT of step block, mode toggled during load");
        for (int i = 0; i < 64; i++) begin
            in_mem[i]   = (i % 8 < 4) ? 64 : -64;
            orig_mem[i] = in_mem[i];
            exp_mem[i]  = 0;
        end
        exp_mem[1] = 464;
        exp_mem[3] = -164;
        exp_mem[5] = 110;
        exp_mem[7] = -93;
        applyStimulus(1'b1, 1'b1);
        waitForOutput();
        checkOutput(1'b0);

        $display("[TB] IDCT round trip with output backpressure");
        for (int i = 0; i < 64; i++) begin
            in_mem[i]  = got_mem[i];
            exp_mem[i] = orig_mem[i];
        end
        tol = 1;
        applyStimulus(1'b0, 1'b1);
        waitForOutput();
        checkOutput(1'b1);
        tol = 0;

        $display("[TB] reset during first pass");
        for (int i = 0; i < 64; i++) begin
            in_mem[i]  = (i == 0) ? 64 : 0;
            exp_mem[i] = 8;
        end
        applyStimulus(1'b0, 1'b0);
        in_valid = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        expectEqual("busy_mid_pass1", busy, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        expectEqual("reset_in_ready", in_ready, 1);
        expectEqual("reset_busy", busy, 0);
        expectEqual("reset_out_valid", out_valid, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0);
        waitForOutput();
        checkOutput(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dct2d_engine.md
# dct2d_engine

Clocked, parametrised 8×8 two-dimensional transform engine, successor to the combinational IDCT block. It performs either inverse DCT or forward DCT, selected per block. Samples stream in and out over valid/ready handshakes in raster order, and the engine evaluates the transform by row-column decomposition on a single time-shared multiply-accumulate unit. It sits between the coefficient/sample source and the display/capture logic.

## Interface
- DW, 10: signed input sample width.
- OW, 10: signed output sample width.
- MW, 16: signed width of the intermediate (transpose) buffer entries.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- mode  in  1  transform select, 0 = IDCT, 1 = forward DCT; sampled on the first accepted input beat of a block.
- in_valid  in  1  input beat valid.
- in_data  in  DW  signed input sample; block element index r*8+c, raster order.
- in_ready  out  1  engine accepting input.
- out_valid  out  1  output beat valid.
- out_data  out  OW  signed result sample.
- out_addr  out  6  raster index (r*8+c) of out_data.
- out_ready  in  1  downstream accepting output.
- busy  out  1  high in PASS1/PASS2/OUT.

## Operation
- Coefficient ROM (constant, 64 × 13-bit signed): K[u][x] = round(4096·c(u)/2·cos((2x+1)uπ/16)), where c(0)=1/√2 and c(u>0)=1. Rounding is half away from zero, so K[0][x]=1448.
- IDCT: f[y][x] = Σu Σv K[u][y]·K[v][x]·F[u][v].
  - PASS1: T[u][x] = Σv F[u][v]·K[v][x].
  - PASS2: out[y][x] = Σu K[u][y]·T[u][x].
- DCT: F[u][v] = Σy Σx K[u][y]·K[v][x]·f[y][x].
  - PASS1: T[y][v] = Σx f[y][x]·K[v][x].
  - PASS2: out[u][v] = Σy K[u][y]·T[y][v].
- Arithmetic:
  - Products are full precision. The accumulator holds all 8 terms without overflow.
  - Each 8-term sum is rounded: add 2048, then arithmetic shift right 12.
  - Saturation: to MW after PASS1, to OW after PASS2.
- States:
  - LOAD: in_ready=1. On each accept, write the input buffer at a 6-bit write counter. After accept #64 → PASS1.
  - PASS1: 512 cycles, one MAC per cycle. The result index advances every 8 cycles. The T buffer is written after each 8th MAC. Then → PASS2.
  - PASS2: 512 cycles, same structure. Writes the output buffer. Then → OUT.
  - OUT: out_valid=1, presenting output buffer entries in raster order 0..63. After the accept of index 63 → LOAD.
- Block mode is latched at accept #0. Changing mode mid-block has no effect.
- in_valid outside LOAD is ignored; nothing is stored.
- Reset at any point: all counters are cleared and the state returns to LOAD. The partial block is discarded. Buffer contents need not be cleared.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, busy=0, out_data=0, out_addr=0.
  - Internal state=LOAD, all counters 0.
- Input throughput: 1 sample/cycle while in_valid stays high.
- Latency: with accept #64 on edge E, out_valid first rises after edge E+1026. This is 1024 MAC cycles plus 2 pipeline/writeback cycles. in_ready falls after edge E.
- Output handshake:
  - A beat transfers on a clock edge where out_valid & out_ready are both high.
  - While out_ready=0, out_data and out_addr are held stable.
  - With out_ready held high, 64 beats come out on consecutive cycles.
- Wrap-around: in_ready rises in the cycle after the index-63 transfer. A new block may be accepted on the next edge; there is no bubble beyond that.
- Minimum block period with no stalls: 64 + 1026 + 64 cycles.

## Test plan
- IDCT DC: mode=0, F[0]=64, all other entries 0 → all 64 outputs = 8, out_addr 0..63 in order.
- IDCT rounding: mode=0, F[0]=511, rest 0 → all outputs = 64. PASS1 intermediate = 181.
- DCT saturation: mode=1, all 64 inputs = 511 → out[0] = 511 (saturated from 4087), all other outputs = 0.
- Round trip: DCT of an arbitrary signed block, with results fed back as IDCT input at mode=0 → each output is within ±1 of the original sample. Mode toggled mid-load has no effect.
- Backpressure: out_ready toggled pseudo-randomly during OUT → no beat lost or duplicated, data stable while stalled, and in_ready=0 until index 63 is transferred.
- Reset mid-PASS1: assert reset at cycle 300 of PASS1 → next cycle in_ready=1, busy=0, out_valid=0. A following full block produces correct results.
